// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : MIPS instruction-fetch controller. Owns the PC, sequences the
//            combinational-read instruction memory and registers the IF/ID
//            boundary. Handles stall, branch redirect, halt and fetch faults.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] MemAddress,
    input  logic [31:0] MemInstruction,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4Out,
    output logic        InstrValid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);
    localparam logic [31:0] c_count_max = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4_out;
    logic        r_valid;
    logic [31:0] r_count;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] w_pc4_out_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_count_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_word_idx;
    logic        w_out_of_range;
    logic [31:0] w_count_inc;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_word_idx     = {2'b00, r_pc[31:2]};
    assign w_out_of_range = (w_word_idx >= c_mem_words);
    assign w_count_inc    = (r_count == c_count_max) ? r_count : r_count + 32'd1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_pc_out  <= 32'd0;
            r_pc4_out <= 32'd0;
            r_valid   <= 1'b0;
            r_count   <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_pc_out  <= w_pc_out_nxt;
            r_pc4_out <= w_pc4_out_nxt;
            r_valid   <= w_valid_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        w_pc_out_nxt  = r_pc_out;
        w_pc4_out_nxt = r_pc4_out;
        w_valid_nxt   = r_valid;
        w_count_nxt   = r_count;

        case (r_state)
            S_IDLE: begin
                w_pc_nxt    = RESET_PC;
                w_valid_nxt = 1'b0;
                if (Start) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // Redirect outranks every other condition, including stall and halt.
                if (BranchTaken) begin
                    w_valid_nxt = 1'b0;
                    if (BranchTarget[1:0] != 2'b00) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_pc_nxt = BranchTarget;
                    end
                end else if (w_out_of_range) begin
                    w_state_nxt = S_FAULT;
                    w_valid_nxt = 1'b0;
                end else if (Stall) begin
                    w_state_nxt = S_RUN;
                end else if (MemInstruction == HALT_WORD) begin
                    // PC stays parked on the halt word; it is never issued.
                    w_state_nxt = S_HALTED;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_instr_nxt   = MemInstruction;
                    w_pc_out_nxt  = r_pc;
                    w_pc4_out_nxt = w_pc_plus4;
                    w_valid_nxt   = 1'b1;
                    w_pc_nxt      = w_pc_plus4;
                    w_count_nxt   = w_count_inc;
                end
            end

            S_HALTED, S_FAULT: begin
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign MemAddress = r_pc;
    assign InstrOut   = r_instr;
    assign PCOut      = r_pc_out;
    assign PCPlus4Out = r_pc4_out;
    assign InstrValid = r_valid;
    assign FetchCount = r_count;
    assign Halted     = (r_state == S_HALTED);
    assign Fault      = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Directed bench for fetch_sequencer: scoreboard of expected issues plus
// point checks for stall, branch, halt, fault and asynchronous reset.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'h0000_000C;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } issue_t;

    logic        clk = 1'b0;
    logic [31:0] mem [0:1023];

    // Main instance (MEM_WORDS = 1024)
    logic        rst0_n, start0, stall0, br0;
    logic [31:0] tgt0, addr0, rd0, instr0, pc0, pc40, cnt0;
    logic        valid0, halted0, fault0;

    // Small-memory instance (MEM_WORDS = 8)
    logic        rst1_n, start1;
    logic [31:0] addr1, rd1, instr1, pc1, pc41, cnt1;
    logic        valid1, halted1, fault1;

    issue_t      exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mpc;
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    always_comb rd0 = (addr0[31:12] == 20'd0) ? mem[addr0[11:2]] : 32'h0;
    always_comb rd1 = (addr1[31:12] == 20'd0) ? mem[addr1[11:2]] : 32'h0;

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(1024), .HALT_WORD(HALT)) dut0 (
        .Clk(clk), .Reset(rst0_n), .Start(start0), .Stall(stall0),
        .BranchTaken(br0), .BranchTarget(tgt0), .MemAddress(addr0),
        .MemInstruction(rd0), .InstrOut(instr0), .PCOut(pc0),
        .PCPlus4Out(pc40), .InstrValid(valid0), .Halted(halted0),
        .Fault(fault0), .FetchCount(cnt0)
    );

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(8), .HALT_WORD(HALT)) dut1 (
        .Clk(clk), .Reset(rst1_n), .Start(start1), .Stall(1'b0),
        .BranchTaken(1'b0), .BranchTarget(32'h0), .MemAddress(addr1),
        .MemInstruction(rd1), .InstrOut(instr1), .PCOut(pc1),
        .PCPlus4Out(pc41), .InstrValid(valid1), .Halted(halted1),
        .Fault(fault1), .FetchCount(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        issue_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("issue_valid", {31'd0, valid0}, 32'd1);
            check("issue_instr", instr0, e.instr);
            check("issue_pc", pc0, e.pc);
            check("issue_pc4", pc40, e.pc + 32'd4);
        end
    endtask

    task automatic run_fetch(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{instr: mem[mpc[11:2]], pc: mpc});
            tick();
            pop_check();
            mpc  = mpc + 32'd4;
            mcnt = mcnt + 32'd1;
        end
    endtask

    task automatic reset_start();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_no_valid", {31'd0, valid0}, 32'd0);
        mpc  = 32'h0;
        mcnt = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3);
        mem[4] = 32'hDEAD_0004;  // i*3 would be the halt encoding at i=4
        rst0_n = 1'b0; start0 = 1'b0; stall0 = 1'b0; br0 = 1'b0; tgt0 = 32'h0;
        rst1_n = 1'b0; start1 = 1'b0;
        mpc = 32'h0; mcnt = 32'h0;

        // Reset state
        #12;
        check("rst_addr", addr0, 32'h0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_instr", instr0, 32'h0);
        check("rst_cnt", cnt0, 32'h0);
        check("rst_flags", {30'd0, halted0, fault0}, 32'd0);
        rst0_n = 1'b1;
        stall0 = 1'b1; br0 = 1'b1; tgt0 = 32'h80;
        tick();
        tick();
        check("idle_ignores_inputs", addr0, 32'h0);
        check("idle_valid", {31'd0, valid0}, 32'd0);
        stall0 = 1'b0; br0 = 1'b0; tgt0 = 32'h0;

        // Start: first valid two edges after Start
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_no_valid", {31'd0, valid0}, 32'd0);
        run_fetch(4);
        check("cnt_after4", cnt0, mcnt);
        check("pc_at_0x10", addr0, 32'h10);

        // Stall for 3 cycles
        stall0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", instr0, 32'd9);
            check("stall_pc", pc0, 32'hC);
            check("stall_cnt", cnt0, 32'd4);
            check("stall_addr", addr0, 32'h10);
        end
        stall0 = 1'b0;
        run_fetch(2);
        check("cnt_after_stall", cnt0, mcnt);

        // Branch with concurrent stall
        br0 = 1'b1; tgt0 = 32'h40; stall0 = 1'b1;
        tick();
        br0 = 1'b0; stall0 = 1'b0;
        check("branch_flush", {31'd0, valid0}, 32'd0);
        check("branch_addr", addr0, 32'h40);
        check("branch_cnt", cnt0, mcnt);
        mpc = 32'h40;
        run_fetch(2);
        check("cnt_after_branch", cnt0, mcnt);

        // Misaligned branch target
        reset_start();
        run_fetch(2);
        br0 = 1'b1; tgt0 = 32'h42;
        tick();
        br0 = 1'b0; tgt0 = 32'h0;
        check("bfault_fault", {31'd0, fault0}, 32'd1);
        check("bfault_valid", {31'd0, valid0}, 32'd0);
        check("bfault_halted", {31'd0, halted0}, 32'd0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        check("bfault_sticky", {31'd0, fault0}, 32'd1);
        check("bfault_cnt", cnt0, 32'd2);

        // Range fault on the 8-word instance
        rst1_n = 1'b1;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        begin
            int budget = 30;
            while (!fault1 && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("rfault_fault", {31'd0, fault1}, 32'd1);
        check("rfault_cnt", cnt1, 32'd8);
        check("rfault_addr", addr1, 32'h20);
        check("rfault_valid", {31'd0, valid1}, 32'd0);
        check("rfault_last_pc", pc1, 32'h1C);

        // Halt at word 5
        mem[5] = HALT;
        reset_start();
        run_fetch(5);
        tick();
        check("halt_flag", {31'd0, halted0}, 32'd1);
        check("halt_valid", {31'd0, valid0}, 32'd0);
        check("halt_cnt", cnt0, 32'd5);
        check("halt_addr", addr0, 32'h14);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        check("halt_sticky", {31'd0, halted0}, 32'd1);
        check("halt_addr_frozen", addr0, 32'h14);
        check("halt_no_fault", {31'd0, fault0}, 32'd0);
        mem[5] = 32'd15;

        // Asynchronous reset between edges
        reset_start();
        run_fetch(3);
        #2;
        rst0_n = 1'b0;
        #1;
        check("arst_addr", addr0, 32'h0);
        check("arst_instr", instr0, 32'h0);
        check("arst_pc", pc0, 32'h0);
        check("arst_pc4", pc40, 32'h0);
        check("arst_valid", {31'd0, valid0}, 32'd0);
        check("arst_cnt", cnt0, 32'h0);
        check("arst_flags", {30'd0, halted0, fault0}, 32'd0);
        tick();
        rst0_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
